// File: rtl/count_capture_fifo_if.sv
// Readout stream between the capture FIFO and the logging stage.
//   out_data  : {epoch, count} at FIFO head
//   out_valid : head entry valid
//   out_ready : consumer accepts head this cycle
interface count_capture_fifo_if #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned EPOCH_W = 8
);
    logic [EPOCH_W+DATA_W-1:0] out_data;
    logic                      out_valid;
    logic                      out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/count_capture_fifo.sv
// Snapshots an upstream free-running counter on each capture strobe, tags it
// with an overflow epoch (count of OV pulses) and queues the extended
// timestamp in a small FIFO drained over a valid/ready stream.
//   clk, reset   : clock, synchronous active-low reset
//   i_count_in   : upstream counter value
//   i_ov_in      : upstream overflow pulse
//   i_capture    : capture request
//   i_clr_drop   : clears the sticky dropped flag
//   bus          : readout stream (out_data / out_valid / out_ready)
//   o_full, o_empty, o_level : FIFO occupancy
//   o_epoch      : current overflow epoch
//   o_dropped    : sticky, a capture was lost to a full FIFO
module count_capture_fifo #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned EPOCH_W = 8,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned ADDR_W  = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DATA_W-1:0]      i_count_in,
    input  logic                   i_ov_in,
    input  logic                   i_capture,
    input  logic                   i_clr_drop,
    count_capture_fifo_if.master   bus,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [ADDR_W:0]        o_level,
    output logic [EPOCH_W-1:0]     o_epoch,
    output logic                   o_dropped
);

    localparam int unsigned OUT_W = EPOCH_W + DATA_W;
    localparam int unsigned LVL_W = ADDR_W + 1;

    logic [OUT_W-1:0]   r_mem [DEPTH];
    logic [ADDR_W-1:0]  r_wr_ptr;
    logic [ADDR_W-1:0]  r_rd_ptr;
    logic [LVL_W-1:0]   r_level;
    logic               r_full;
    logic               r_empty;
    logic               r_valid;
    logic [EPOCH_W-1:0] r_epoch;
    logic               r_dropped;
    logic [OUT_W-1:0]   r_head;

    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic [EPOCH_W-1:0] w_epoch_inc;
    logic [OUT_W-1:0]   w_wdata;
    logic [ADDR_W-1:0]  w_wr_ptr_nxt;
    logic [ADDR_W-1:0]  w_rd_ptr_nxt;
    logic [LVL_W-1:0]   w_level_nxt;
    logic [OUT_W-1:0]   w_head_nxt;

    // Handshake decode and next-state computation
    always_comb begin
        w_pop        = r_valid && bus.out_ready;
        w_push       = i_capture && (!r_full || w_pop);
        w_drop       = i_capture && r_full && !w_pop;
        w_epoch_inc  = r_epoch + EPOCH_W'(1);
        // A capture coincident with OV already sees the wrapped count,
        // so it belongs to the next epoch.
        w_wdata      = {(i_ov_in ? w_epoch_inc : r_epoch), i_count_in};
        w_wr_ptr_nxt = w_push ? r_wr_ptr + ADDR_W'(1) : r_wr_ptr;
        w_rd_ptr_nxt = w_pop  ? r_rd_ptr + ADDR_W'(1) : r_rd_ptr;

        w_level_nxt = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + LVL_W'(1);
            2'b01:   w_level_nxt = r_level - LVL_W'(1);
            default: w_level_nxt = r_level;
        endcase

        // Registered head: bypass the write that lands in the next head slot
        if (w_level_nxt == LVL_W'(0)) begin
            w_head_nxt = '0;
        end else if (w_push && (r_wr_ptr == w_rd_ptr_nxt)) begin
            w_head_nxt = w_wdata;
        end else begin
            w_head_nxt = r_mem[w_rd_ptr_nxt];
        end
    end

    // Storage array; contents are don't-care while not counted by level
    always_ff @(posedge clk) begin
        if (w_push && reset) begin
            r_mem[r_wr_ptr] <= w_wdata;
        end
    end

    // Control and status registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_full    <= 1'b0;
            r_empty   <= 1'b1;
            r_valid   <= 1'b0;
            r_epoch   <= '0;
            r_dropped <= 1'b0;
            r_head    <= '0;
        end else begin
            r_wr_ptr  <= w_wr_ptr_nxt;
            r_rd_ptr  <= w_rd_ptr_nxt;
            r_level   <= w_level_nxt;
            r_full    <= (w_level_nxt == LVL_W'(DEPTH));
            r_empty   <= (w_level_nxt == LVL_W'(0));
            r_valid   <= (w_level_nxt != LVL_W'(0));
            r_head    <= w_head_nxt;
            if (i_ov_in) begin
                r_epoch <= w_epoch_inc;
            end
            // A new drop takes priority over a clear in the same cycle
            if (w_drop) begin
                r_dropped <= 1'b1;
            end else if (i_clr_drop) begin
                r_dropped <= 1'b0;
            end
        end
    end

    assign bus.out_data  = r_head;
    assign bus.out_valid = r_valid;
    assign o_full        = r_full;
    assign o_empty       = r_empty;
    assign o_level       = r_level;
    assign o_epoch       = r_epoch;
    assign o_dropped     = r_dropped;

endmodule
